mcu_fpga_bus_ctrl: RTL

Parametrised successor to the MCU-FPGA parallel register bus. It provides a full four-phase strobe/ack handshake for both writes and reads between an asynchronous MCU master and the FPGA register banks. It adds metastability-safe strobe synchronisation, read-back of input pin state, out-of-range address detection and per-register write pulses. It sits between the MCU pin interface and the pin I/O logic, all in the CLK50 domain.

---
 rtl/mcu_fpga_bus_ctrl_if.sv | 39 +++
 rtl/mcu_fpga_bus_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mcu_fpga_bus_ctrl_if.sv
// MCU parallel register bus: strobe/ack handshake plus address and data lines.
// Optional MCU_BUS_PARITY_EN adds the mcu_parity line (even parity over
// {write_enable, address, data_in}).
interface mcu_fpga_bus_ctrl_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
);
  logic              mcu_mstr;
  logic              write_enable;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic              fpga_ack;
  logic              bus_err;
`ifdef MCU_BUS_PARITY_EN
  logic              mcu_parity;

  modport master (
    output mcu_mstr, write_enable, address, data_in, mcu_parity,
    input  data_out, data_oe, fpga_ack, bus_err
  );

  modport slave (
    input  mcu_mstr, write_enable, address, data_in, mcu_parity,
    output data_out, data_oe, fpga_ack, bus_err
  );
`else
  modport master (
    output mcu_mstr, write_enable, address, data_in,
    input  data_out, data_oe, fpga_ack, bus_err
  );

  modport slave (
    input  mcu_mstr, write_enable, address, data_in,
    output data_out, data_oe, fpga_ack, bus_err
  );
`endif
endinterface

// File: rtl/mcu_fpga_bus_ctrl.sv
// MCU-FPGA parallel register bus controller (CLK50 domain).
// Synchronises the asynchronous MCU strobe, runs a four-phase strobe/ack
// handshake, writes the output pin bank and reads back the input pin bank.
// Optional feature macro: MCU_BUS_PARITY_EN (parity check on captured request).
module mcu_fpga_bus_ctrl #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                             CLK50,
  input  logic                             RST_N,
  mcu_fpga_bus_ctrl_if.slave               bus,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  input_pins_state,
  output logic [NUM_REGS-1:0][DATA_W-1:0]  output_pins_state,
  output logic [NUM_REGS-1:0]              wr_strobe
);

  localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(NUM_REGS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  state_e                           state_q, state_d;
  logic [1:0]                       rst_sync_q;
  logic                             rst_n;
  logic [SYNC_STAGES-1:0]           mstr_sync_q;
  logic                             s_mstr;
  logic [ADDR_W-1:0]                addr_q, addr_d;
  logic                             we_q, we_d;
  logic [DATA_W-1:0]                wdata_q, wdata_d;
  logic [DATA_W-1:0]                data_out_q, data_out_d;
  logic                             data_oe_q, data_oe_d;
  logic                             fpga_ack_q, fpga_ack_d;
  logic                             bus_err_q, bus_err_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]  out_pins_q, out_pins_d;
  logic [NUM_REGS-1:0]              wr_strobe_q, wr_strobe_d;
  logic [DATA_W-1:0]                rd_data_c;
  logic                             in_range_c;
  logic                             par_ok_c;
  logic                             txn_ok_c;

  // Reset: asynchronous assert, deassert released through two flops
  always_ff @(posedge CLK50 or negedge RST_N) begin
    if (!RST_N) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // Strobe synchroniser; only s_mstr reaches the FSM
  always_ff @(posedge CLK50 or negedge rst_n) begin
    if (!rst_n) mstr_sync_q <= '0;
    else        mstr_sync_q <= {mstr_sync_q[SYNC_STAGES-2:0], bus.mcu_mstr};
  end
  assign s_mstr = mstr_sync_q[SYNC_STAGES-1];

`ifdef MCU_BUS_PARITY_EN
  logic par_q, par_d;
  // Even parity: the captured parity bit equals the XOR of the request fields
  assign par_ok_c = (par_q == ^{we_q, addr_q, wdata_q});
`else
  assign par_ok_c = 1'b1;
`endif

  // Address range check is one bit wider so NUM_REGS == 2**ADDR_W works
  assign in_range_c = ({1'b0, addr_q} < REG_LIMIT);
  assign txn_ok_c   = in_range_c & par_ok_c;

  // Read mux over the input pin bank
  always_comb begin
    rd_data_c = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (addr_q == ADDR_W'(i)) rd_data_c = input_pins_state[i];
    end
  end

  // FSM state register
  always_ff @(posedge CLK50 or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (s_mstr) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_ACK;
      ST_ACK:  if (!s_mstr) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: next values of capture, handshake and register-bank flops
  always_comb begin
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
`ifdef MCU_BUS_PARITY_EN
    par_d       = par_q;
`endif
    data_out_d  = data_out_q;
    data_oe_d   = data_oe_q;
    fpga_ack_d  = fpga_ack_q;
    bus_err_d   = bus_err_q;
    out_pins_d  = out_pins_q;
    wr_strobe_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (s_mstr) begin
          addr_d  = bus.address;
          we_d    = bus.write_enable;
          wdata_d = bus.data_in;
`ifdef MCU_BUS_PARITY_EN
          par_d   = bus.mcu_parity;
`endif
        end
      end
      ST_EXEC: begin
        fpga_ack_d = 1'b1;
        data_oe_d  = ~we_q;
        bus_err_d  = ~txn_ok_c;
        if (!txn_ok_c) begin
          data_out_d = '0;
        end else if (we_q) begin
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (addr_q == ADDR_W'(i)) begin
              out_pins_d[i]  = wdata_q;
              wr_strobe_d[i] = 1'b1;
            end
          end
        end else begin
          data_out_d = rd_data_c;
        end
      end
      ST_ACK: begin
        if (!s_mstr) begin
          fpga_ack_d = 1'b0;
          data_oe_d  = 1'b0;
          bus_err_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and handshake registers
  always_ff @(posedge CLK50 or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
`ifdef MCU_BUS_PARITY_EN
      par_q       <= 1'b0;
`endif
      data_out_q  <= '0;
      data_oe_q   <= 1'b0;
      fpga_ack_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      out_pins_q  <= '0;
      wr_strobe_q <= '0;
    end else begin
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
`ifdef MCU_BUS_PARITY_EN
      par_q       <= par_d;
`endif
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
      fpga_ack_q  <= fpga_ack_d;
      bus_err_q   <= bus_err_d;
      out_pins_q  <= out_pins_d;
      wr_strobe_q <= wr_strobe_d;
    end
  end

  assign bus.data_out       = data_out_q;
  assign bus.data_oe        = data_oe_q;
  assign bus.fpga_ack       = fpga_ack_q;
  assign bus.bus_err        = bus_err_q;
  assign output_pins_state  = out_pins_q;
  assign wr_strobe          = wr_strobe_q;

endmodule
